// File: rtl/neuron_accumulator.sv
// ============================================================================
// neuron_accumulator: reduces each row of a product matrix to a neuron output
// with bias, optional ReLU and sign-magnitude saturation.  Rev 1.0
// ============================================================================
`default_nettype none

module neuron_accumulator #(
  parameter int R  = 6,
  parameter int C  = 6,
  parameter int N  = 32,
  parameter int Q  = 17,
  localparam int IW = (R > 1) ? $clog2(R) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] prod_i [0:R-1][0:C-1],
  input  logic [N-1:0] bias_i [0:R-1],
  input  logic         relu_en_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] out_data_o,
  output logic [IW-1:0] out_idx_o,
  output logic         out_last_o,
  output logic         overflow_o
);

  localparam int AW  = N + $clog2(C + 1) + 1;
  localparam int CWD = (C > 1) ? $clog2(C) : 1;
  localparam logic [AW-1:0] MAXM = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};

  if (Q < 0 || Q > N - 1) begin : g_bad_q
    $error("neuron_accumulator: Q must lie in 0..N-1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_BIAS = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          row_q, row_d;
  logic [CWD-1:0]         col_q, col_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic                   relu_q, relu_d;
  logic                   out_valid_q, out_valid_d;
  logic [N-1:0]           out_data_q, out_data_d;
  logic [IW-1:0]          out_idx_q, out_idx_d;
  logic                   out_last_q, out_last_d;
  logic                   ovf_q, ovf_d;

  logic [N-1:0] prod_q [0:R-1][0:C-1];
  logic [N-1:0] bias_q [0:R-1];

  logic signed [AW-1:0] res;
  logic [AW-1:0]        mag;
  logic                 neg;

  // Sign-magnitude to two's complement; negative zero naturally maps to 0.
  function automatic logic signed [AW-1:0] sm2tc(input logic [N-1:0] v);
    logic signed [AW-1:0] m;
    m = {{(AW-N+1){1'b0}}, v[N-2:0]};
    return v[N-1] ? -m : m;
  endfunction

  wire w_capture = (state_q == S_IDLE) && in_valid_i;

  always_ff @(posedge clk) begin
    if (w_capture) begin
      prod_q <= prod_i;
      bias_q <= bias_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    acc_d       = acc_q;
    relu_d      = relu_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    ovf_d       = ovf_q;
    res         = acc_q + sm2tc(bias_q[row_q]);
    mag         = '0;
    neg         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          relu_d  = relu_en_i;
          row_d   = '0;
          col_d   = '0;
          acc_d   = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        acc_d = acc_q + sm2tc(prod_q[row_q][col_q]);
        if (col_q == CWD'(C - 1)) begin
          col_d   = '0;
          state_d = S_BIAS;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_BIAS: begin
        if (relu_q && res < 0) res = '0;
        neg = (res < 0);
        mag = neg ? $unsigned(-res) : $unsigned(res);
        ovf_d = 1'b0;
        if (mag > MAXM) begin
          mag   = MAXM;
          ovf_d = 1'b1;
        end
        out_data_d  = {neg, mag[N-2:0]};
        out_idx_d   = row_q;
        out_last_d  = (row_q == IW'(R - 1));
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          if (row_q != IW'(R - 1)) begin
            row_d   = row_q + 1'b1;
            col_d   = '0;
            state_d = S_ACC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      acc_q       <= '0;
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
      relu_q      <= relu_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;
  assign out_last_o  = out_last_q;
  assign overflow_o  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_neuron_accumulator.sv
// Randomized scoreboard bench for neuron_accumulator with an integer reference model.
`default_nettype none

module tb_neuron_accumulator;
  localparam int R = 6, C = 6, N = 32, IW = 3, LIMIT = 400;
  localparam longint MAXV = 64'h7FFF_FFFF;

  typedef struct {
    logic [31:0] data;
    int          idx;
    bit          last;
    bit          ovf;
  } exp_t;

  logic          clk = 0, rst_n = 0;
  logic          in_valid = 0, in_ready, relu_en = 0;
  logic [N-1:0]  prod [0:R-1][0:C-1];
  logic [N-1:0]  bias [0:R-1];
  logic          out_valid, out_ready = 1, out_last, overflow;
  logic [N-1:0]  out_data;
  logic [IW-1:0] out_idx;

  logic [N-1:0]  stage_p [0:R-1][0:C-1];
  logic [N-1:0]  stage_b [0:R-1];
  exp_t          sbq[$];
  int            checks = 0, errors = 0, n_pop = 0;
  int            rmode = 0;
  logic          ready_manual = 0;

  neuron_accumulator #(.R(R), .C(C), .N(N), .Q(17)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .prod_i(prod), .bias_i(bias), .relu_en_i(relu_en), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .out_idx_o(out_idx),
    .out_last_o(out_last), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic longint smv(input logic [31:0] w);
    longint m;
    m = longint'(w[30:0]);
    return w[31] ? -m : m;
  endfunction

  // Reference: plain integer sum, clamp, saturate, re-encode.
  function automatic exp_t model(input int r, input logic relu);
    exp_t e;
    longint s, a;
    s = 0;
    for (int c = 0; c < C; c++) s += smv(stage_p[r][c]);
    s += smv(stage_b[r]);
    if (relu && s < 0) s = 0;
    a = (s < 0) ? -s : s;
    e.ovf = (a > MAXV);
    if (e.ovf) a = MAXV;
    e.data = {(s < 0), a[30:0]};
    e.idx  = r;
    e.last = (r == R - 1);
    return e;
  endfunction

  function automatic logic [31:0] rword();
    logic [31:0] w;
    case ($urandom % 6)
      0: w = 32'h8000_0000;
      1: w = 32'h7FFF_FFFF;
      2: w = 32'hFFFF_FFFF;
      3: w = {$urandom_range(1, 0) == 1, 11'd0, 20'($urandom)};
      default: w = $urandom;
    endcase
    return w;
  endfunction

  task automatic fill_const(input logic [31:0] p, input logic [31:0] b);
    for (int r = 0; r < R; r++) begin
      stage_b[r] = b;
      for (int c = 0; c < C; c++) stage_p[r][c] = p;
    end
  endtask

  task automatic fill_rand();
    for (int r = 0; r < R; r++) begin
      stage_b[r] = rword();
      for (int c = 0; c < C; c++) stage_p[r][c] = rword();
    end
  endtask

  task automatic scribble();
    for (int r = 0; r < R; r++) begin
      bias[r] = $urandom;
      for (int c = 0; c < C; c++) prod[r][c] = $urandom;
    end
  endtask

  // Called at posedge+#1; returns at capture edge +#1.
  task automatic send(input logic relu);
    int n = 0;
    prod = stage_p; bias = stage_b; relu_en = relu; in_valid = 1;
    while (!in_ready && n < LIMIT) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      chk("capture_timeout", 32'(n), 32'(LIMIT - 1));
      in_valid = 0;
      return;
    end
    @(posedge clk);
    for (int r = 0; r < R; r++) sbq.push_back(model(r, relu));
    #1;
    in_valid = 0;
    relu_en = ~relu;
    scribble();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < LIMIT) begin @(posedge clk); #1; n++; end
    if (!out_valid) chk("valid_timeout", 32'(n), 32'(LIMIT - 1));
  endtask

  task automatic wait_not_valid();
    int n = 0;
    while (out_valid && n < LIMIT) begin @(posedge clk); #1; n++; end
    if (out_valid) chk("accept_timeout", 32'(n), 32'(LIMIT - 1));
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sbq.size() != 0 || !in_ready) && n < 4 * LIMIT) begin @(posedge clk); #1; n++; end
    chk(name, 32'(sbq.size()), 32'd0);
  endtask

  task automatic pulse_ready();
    ready_manual = 1;
    @(posedge clk); #1;
    ready_manual = 0;
  endtask

  initial begin
    int n;
    exp_t e2;
    fork
      forever begin
        @(posedge clk); #2;
        case (rmode)
          0: out_ready = 1'b1;
          1: out_ready = ($urandom % 3) != 0;
          default: out_ready = ready_manual;
        endcase
      end
      forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            chk("unexpected_output", {29'd0, out_idx}, 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            n_pop++;
            chk("out_data", out_data, e.data);
            chk("out_idx", 32'(out_idx), 32'(e.idx));
            chk("out_last", 32'(out_last), 32'(e.last));
            chk("overflow", 32'(overflow), 32'(e.ovf));
          end
        end
      end
    join_none

    scribble();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_last_ovf", {30'd0, out_last, overflow}, 32'd0);
    rst_n = 1;
    @(posedge clk); #1;

    // Basic sum with latency checks
    fill_const(32'h0002_0000, 32'h8001_0000);
    send(1'b0);
    wait_valid(n);
    chk("latency_first", 32'(n), 32'(C + 1));
    chk("basic_value", out_data, 32'h000B_0000);
    wait_not_valid();
    wait_valid(n);
    chk("latency_next", 32'(n), 32'(C + 1));
    drain("drain_basic");

    fill_const(32'h8002_0000, 32'h0000_0000);
    send(1'b0);
    drain("drain_neg");
    send(1'b1);
    drain("drain_relu");
    fill_const(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    send(1'b0);
    drain("drain_sat_pos");
    fill_const(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(1'b1);
    send(1'b0);
    drain("drain_sat_neg");
    for (int r = 0; r < R; r++) begin
      stage_b[r] = 32'h8000_0000;
      for (int c = 0; c < C; c++) stage_p[r][c] = c[0] ? 32'h8002_0000 : 32'h0002_0000;
    end
    send(1'b0);
    drain("drain_cancel");

    // Backpressure on neuron 2, with a stray in_valid during the hold
    rmode = 2;
    ready_manual = 0;
    fill_rand();
    e2 = model(2, 1'b0);
    send(1'b0);
    for (int i = 0; i < R; i++) begin
      wait_valid(n);
      if (i == 2) begin
        fill_rand();
        prod = stage_p; bias = stage_b; in_valid = 1;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          chk("bp_valid", 32'(out_valid), 32'd1);
          chk("bp_data", out_data, e2.data);
          chk("bp_idx", 32'(out_idx), 32'd2);
          chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
      end
      pulse_ready();
    end
    in_valid = 0;
    @(posedge clk); #1;
    chk("bp_in_ready_idle", 32'(in_ready), 32'd1);
    drain("drain_bp");
    rmode = 0;

    // Randomized back-to-back matrices with random backpressure
    rmode = 1;
    for (int t = 0; t < 8; t++) begin
      fill_rand();
      send(1'($urandom));
    end
    drain("drain_rand");
    rmode = 0;

    // Reset while row 3 is accumulating
    fill_rand();
    n = n_pop;
    send(1'b0);
    for (int k = 0; k < LIMIT && n_pop < n + 3; k++) begin @(posedge clk); #1; end
    chk("pre_reset_pops", 32'(n_pop - n), 32'd3);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_idx_last_ovf", {27'd0, out_idx, out_last, overflow}, 32'd0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (C + 4) @(posedge clk);
    #1;
    chk("post_rst_quiet", 32'(out_valid), 32'd0);
    fill_rand();
    send(1'b1);
    drain("drain_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
